// File: rtl/cp0_exc_unit_pkg.sv
// Coprocessor-0 shared definitions: register indices, exception codes and
// Status/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_RI  = 5'd10,
    EXC_OV  = 5'd12
  } exc_code_e;

  localparam int unsigned STATUS_IE     = 0;
  localparam int unsigned STATUS_EXL    = 1;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_IP_BIT  = 10;

endpackage

// File: rtl/cp0_exc_unit_if.sv
// CPU <-> CP0 signal bundle; the CPU side is the master, CP0 the slave.
interface cp0_exc_unit_if;
  logic [31:0] pc;
  logic        v;
  logic        ov_en;
  logic        sys;
  logic        unimpl;
  logic        intr;
  logic        mtc0;
  logic        mfc0;
  logic        eret;
  logic [4:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        kill;
  logic        inta;

  modport master (
    output pc, v, ov_en, sys, unimpl, intr, mtc0, mfc0, eret, sel, wdata,
    input  rdata, redirect, redirect_pc, kill, inta
  );

  modport slave (
    input  pc, v, ov_en, sys, unimpl, intr, mtc0, mfc0, eret, sel, wdata,
    output rdata, redirect, redirect_pc, kill, inta
  );
endinterface

// File: rtl/cp0_exc_unit_int_sync.sv
// Flop-chain synchronizer for the asynchronous interrupt level.
module int_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic clrn,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt unit: Status/Cause/EPC, priority encoding of
// exception sources, redirect target selection and instruction kill.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_BASE    = 32'h0000_0008,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               clrn,
  cp0_exc_unit_if.slave      bus
);
  logic        ie, exl, ip;
  exc_code_e   exc_code;
  logic [31:0] epc;

  logic        ovf, exc_take, int_req, take;
  exc_code_e   take_code;

  int_sync #(.STAGES(SYNC_STAGES)) u_int_sync (
    .clk  (clk),
    .clrn (clrn),
    .d    (bus.intr),
    .q    (ip)
  );

  assign ovf      = bus.v & bus.ov_en;
  assign exc_take = bus.unimpl | bus.sys | ovf;
  // Uses registered Status only, so a same-cycle mtc0 cannot enable a take.
  assign int_req  = ip & ie & ~exl;
  assign take     = exc_take | int_req;

  always_comb begin
    take_code = EXC_INT;
    if      (bus.unimpl) take_code = EXC_RI;
    else if (bus.sys)    take_code = EXC_SYS;
    else if (ovf)        take_code = EXC_OV;
  end

  // Outputs gated by clrn so nothing escapes while reset is held.
  assign bus.redirect    = clrn & (take | bus.eret);
  assign bus.redirect_pc = take ? EXC_BASE : epc;
  assign bus.kill        = clrn & take;
  assign bus.inta        = clrn & int_req & ~exc_take;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ie       <= 1'b0;
      exl      <= 1'b0;
      exc_code <= EXC_INT;
      epc      <= '0;
    end else if (take) begin
      epc      <= bus.pc;
      exc_code <= take_code;
      exl      <= 1'b1;
    end else begin
      if (bus.mtc0) begin
        case (bus.sel)
          REG_STATUS: begin
            ie  <= bus.wdata[STATUS_IE];
            exl <= bus.wdata[STATUS_EXL];
          end
          REG_EPC: epc <= bus.wdata;
          default: ;
        endcase
      end
      if (bus.eret) exl <= 1'b0;
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.sel)
      REG_STATUS: begin
        bus.rdata[STATUS_IE]  = ie;
        bus.rdata[STATUS_EXL] = exl;
      end
      REG_CAUSE: begin
        bus.rdata[CAUSE_EXC_LSB +: 5] = exc_code;
        bus.rdata[CAUSE_IP_BIT]       = ip;
      end
      REG_EPC: bus.rdata = epc;
      default: ;
    endcase
  end

  // rdata is always driven; the read strobe carries no extra meaning here.
  logic unused_mfc0;
  assign unused_mfc0 = bus.mfc0;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit (SYNC_STAGES=2).
module tb_cp0_exc_unit;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] rd;

  cp0_exc_unit_if bus ();

  cp0_exc_unit #(.EXC_BASE(32'h0000_0008), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic idle();
    bus.v = 0; bus.ov_en = 0; bus.sys = 0; bus.unimpl = 0;
    bus.mtc0 = 0; bus.mfc0 = 0; bus.eret = 0; bus.sel = 5'd0; bus.wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_cp0(input logic [4:0] s, output logic [31:0] d);
    bus.sel = s; bus.mfc0 = 1;
    #1;
    d = bus.rdata;
    bus.mfc0 = 0;
  endtask

  task automatic write_cp0(input logic [4:0] s, input logic [31:0] d);
    bus.mtc0 = 1; bus.sel = s; bus.wdata = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle(); bus.pc = '0; bus.intr = 0; bus.unimpl = 1;
    #3;
    checks++; if ({bus.redirect, bus.kill, bus.inta} !== 3'b000) begin
      $display("FAIL reset_outputs got=%b exp=000", {bus.redirect, bus.kill, bus.inta}); failures++; end
    read_cp0(5'd12, rd);
    checks++; if (rd !== 32'h0) begin $display("FAIL reset_status got=%h exp=0", rd); failures++; end
    read_cp0(5'd13, rd);
    checks++; if (rd !== 32'h0) begin $display("FAIL reset_cause got=%h exp=0", rd); failures++; end
    read_cp0(5'd14, rd);
    checks++; if (rd !== 32'h0) begin $display("FAIL reset_epc got=%h exp=0", rd); failures++; end
    @(negedge clk);
    clrn = 1; idle();
    #1;
    checks++; if (bus.redirect !== 1'b0) begin $display("FAIL post_reset_redirect got=%b exp=0", bus.redirect); failures++; end
  endtask

  task automatic test_overflow();
    bus.pc = 32'h40; bus.ov_en = 1; bus.v = 1;
    #1;
    checks++; if ({bus.redirect, bus.kill, bus.inta} !== 3'b110) begin
      $display("FAIL ovf_take got=%b exp=110", {bus.redirect, bus.kill, bus.inta}); failures++; end
    checks++; if (bus.redirect_pc !== 32'h8) begin $display("FAIL ovf_target got=%h exp=00000008", bus.redirect_pc); failures++; end
    tick(); idle(); bus.pc = 32'h44;
    read_cp0(5'd14, rd);
    checks++; if (rd !== 32'h40) begin $display("FAIL ovf_epc got=%h exp=00000040", rd); failures++; end
    read_cp0(5'd13, rd);
    checks++; if (rd !== 32'h30) begin $display("FAIL ovf_cause got=%h exp=00000030", rd); failures++; end
    read_cp0(5'd12, rd);
    checks++; if (rd !== 32'h2) begin $display("FAIL ovf_status got=%h exp=00000002", rd); failures++; end
    bus.ov_en = 0; bus.v = 1;
    #1;
    checks++; if ({bus.redirect, bus.kill} !== 2'b00) begin
      $display("FAIL ovf_disabled got=%b exp=00", {bus.redirect, bus.kill}); failures++; end
    tick(); idle();
    read_cp0(5'd14, rd);
    checks++; if (rd !== 32'h40) begin $display("FAIL ovf_disabled_epc got=%h exp=00000040", rd); failures++; end
    write_cp0(5'd12, 32'h0);
  endtask

  task automatic test_priority();
    bus.pc = 32'h60; bus.unimpl = 1; bus.sys = 1; bus.ov_en = 1; bus.v = 1;
    #1;
    checks++; if (bus.kill !== 1'b1) begin $display("FAIL prio_kill got=%b exp=1", bus.kill); failures++; end
    tick(); idle(); bus.pc = 32'h64;
    tick();
    read_cp0(5'd13, rd);
    checks++; if (rd !== 32'h28) begin $display("FAIL prio_cause got=%h exp=00000028", rd); failures++; end
    read_cp0(5'd14, rd);
    checks++; if (rd !== 32'h60) begin $display("FAIL prio_epc got=%h exp=00000060", rd); failures++; end
    write_cp0(5'd12, 32'h0);
  endtask

  task automatic test_interrupt();
    write_cp0(5'd12, 32'h1);
    read_cp0(5'd12, rd);
    checks++; if (rd !== 32'h1) begin $display("FAIL int_setup_status got=%h exp=00000001", rd); failures++; end
    bus.intr = 1; bus.pc = 32'h200;
    #1;
    checks++; if (bus.inta !== 1'b0) begin $display("FAIL int_cycle0 got=%b exp=0", bus.inta); failures++; end
    tick(); bus.pc = 32'h204;
    #1;
    checks++; if ({bus.inta, bus.redirect} !== 2'b00) begin
      $display("FAIL int_cycle1 got=%b exp=00", {bus.inta, bus.redirect}); failures++; end
    tick(); bus.pc = 32'h208;
    #1;
    checks++; if ({bus.inta, bus.redirect, bus.kill} !== 3'b111) begin
      $display("FAIL int_cycle2 got=%b exp=111", {bus.inta, bus.redirect, bus.kill}); failures++; end
    checks++; if (bus.redirect_pc !== 32'h8) begin $display("FAIL int_target got=%h exp=00000008", bus.redirect_pc); failures++; end
    tick(); bus.pc = 32'h20c;
    read_cp0(5'd13, rd);
    checks++; if (rd !== 32'h400) begin $display("FAIL int_cause got=%h exp=00000400", rd); failures++; end
    read_cp0(5'd14, rd);
    checks++; if (rd !== 32'h208) begin $display("FAIL int_epc got=%h exp=00000208", rd); failures++; end
    read_cp0(5'd12, rd);
    checks++; if (rd !== 32'h3) begin $display("FAIL int_status got=%h exp=00000003", rd); failures++; end
  endtask

  task automatic test_exl_masks();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.inta !== 1'b0) begin $display("FAIL exl_mask cycle=%0d got=%b exp=0", i, bus.inta); failures++; end
      tick();
    end
  endtask

  task automatic test_eret();
    write_cp0(5'd14, 32'h100);
    bus.eret = 1; bus.pc = 32'h300;
    #1;
    checks++; if ({bus.redirect, bus.kill, bus.inta} !== 3'b100) begin
      $display("FAIL eret_flags got=%b exp=100", {bus.redirect, bus.kill, bus.inta}); failures++; end
    checks++; if (bus.redirect_pc !== 32'h100) begin $display("FAIL eret_target got=%h exp=00000100", bus.redirect_pc); failures++; end
    tick(); idle(); bus.pc = 32'h104;
    read_cp0(5'd12, rd);
    checks++; if (rd !== 32'h1) begin $display("FAIL eret_status got=%h exp=00000001", rd); failures++; end
    checks++; if (bus.inta !== 1'b1) begin $display("FAIL eret_int_after got=%b exp=1", bus.inta); failures++; end
    tick(); bus.pc = 32'h108;
    read_cp0(5'd14, rd);
    checks++; if (rd !== 32'h104) begin $display("FAIL eret_int_epc got=%h exp=00000104", rd); failures++; end
  endtask

  task automatic test_status_write_vs_int();
    // EXL=1, IE=1, intr synced high: writing EXL=1 must not take.
    bus.mtc0 = 1; bus.sel = 5'd12; bus.wdata = 32'h3;
    #1;
    checks++; if (bus.inta !== 1'b0) begin $display("FAIL mtc0_exl_set got=%b exp=0", bus.inta); failures++; end
    tick(); idle();
    #1;
    checks++; if (bus.inta !== 1'b0) begin $display("FAIL mtc0_exl_after got=%b exp=0", bus.inta); failures++; end
    // Clearing EXL: registered Status still has EXL=1 this cycle.
    bus.mtc0 = 1; bus.sel = 5'd12; bus.wdata = 32'h1;
    #1;
    checks++; if (bus.inta !== 1'b0) begin $display("FAIL mtc0_clear_same got=%b exp=0", bus.inta); failures++; end
    tick(); idle();
    // Interrupt take coinciding with an EPC write: the write is dropped.
    bus.pc = 32'h300; bus.mtc0 = 1; bus.sel = 5'd14; bus.wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if ({bus.inta, bus.kill} !== 2'b11) begin
      $display("FAIL mtc0_int_take got=%b exp=11", {bus.inta, bus.kill}); failures++; end
    tick(); idle();
    read_cp0(5'd14, rd);
    checks++; if (rd !== 32'h300) begin $display("FAIL mtc0_int_epc got=%h exp=00000300", rd); failures++; end
    bus.intr = 0;
    tick(); tick();
    read_cp0(5'd13, rd);
    checks++; if (rd !== 32'h0) begin $display("FAIL intr_drop_cause got=%h exp=00000000", rd); failures++; end
  endtask

  task automatic test_reset_mid_handler();
    write_cp0(5'd14, 32'h80);
    read_cp0(5'd12, rd);
    checks++; if (rd !== 32'h3) begin $display("FAIL mid_pre_status got=%h exp=00000003", rd); failures++; end
    #2;
    clrn = 0; bus.unimpl = 1; bus.intr = 1;
    read_cp0(5'd12, rd);
    checks++; if (rd !== 32'h0) begin $display("FAIL mid_status got=%h exp=0", rd); failures++; end
    read_cp0(5'd13, rd);
    checks++; if (rd !== 32'h0) begin $display("FAIL mid_cause got=%h exp=0", rd); failures++; end
    read_cp0(5'd14, rd);
    checks++; if (rd !== 32'h0) begin $display("FAIL mid_epc got=%h exp=0", rd); failures++; end
    checks++; if ({bus.redirect, bus.kill, bus.inta} !== 3'b000) begin
      $display("FAIL mid_outputs got=%b exp=000", {bus.redirect, bus.kill, bus.inta}); failures++; end
    tick(); tick();
    #1;
    checks++; if ({bus.redirect, bus.kill, bus.inta} !== 3'b000) begin
      $display("FAIL mid_hold_outputs got=%b exp=000", {bus.redirect, bus.kill, bus.inta}); failures++; end
    clrn = 1; idle(); bus.intr = 0;
    #1;
    checks++; if (bus.redirect !== 1'b0) begin $display("FAIL mid_release_redirect got=%b exp=0", bus.redirect); failures++; end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_priority();
    test_interrupt();
    test_exl_masks();
    test_eret();
    test_status_write_vs_int();
    test_reset_mid_handler();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
